// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and an optional second (skid) entry.
// Bubbles drive NOP_VAL. The keep field is sticky. Entries discarded by flush are counted.
module pipe_stage_skid #(
  parameter int              DW      = 32,
  parameter int              KW      = 1,
  parameter logic [DW-1:0]   NOP_VAL = '0,
  parameter int              SKID    = 1,
  parameter int              CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  input  logic [KW-1:0] up_keep,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data,
  output logic [KW-1:0] dn_keep,
  output logic [1:0]    occupancy,
  output logic [CW-1:0] drop_cnt
);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;
  localparam logic [CW:0] DROP_MAX = {1'b0, {CW{1'b1}}};

  logic [1:0]    state, state_nx;
  logic [DW-1:0] main_data, skid_data;
  logic [KW-1:0] main_keep, skid_keep;
  logic          acc, con, ld_up, ld_skid, ld_to_skid;
  logic [1:0]    dec;
  logic [CW:0]   drop_sum;

  // State encoding equals the number of held entries.
  assign occupancy = state;
  assign dn_valid  = (state != ST_EMPTY);
  assign dn_data   = dn_valid ? main_data : NOP_VAL;
  assign dn_keep   = main_keep;
  assign acc       = up_valid & up_ready;
  assign con       = dn_valid & dn_ready;

  always_comb begin
    state_nx   = state;
    ld_up      = 1'b0;
    ld_skid    = 1'b0;
    ld_to_skid = 1'b0;
    if (flush) begin
      state_nx = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (acc) begin
          ld_up    = 1'b1;
          state_nx = ST_ONE;
        end
        ST_ONE: begin
          if (acc && con) begin
            ld_up = 1'b1;
          end else if (acc) begin
            if (SKID != 0) begin
              ld_to_skid = 1'b1;
              state_nx   = ST_TWO;
            end
          end else if (con) begin
            state_nx = ST_EMPTY;
          end
        end
        ST_TWO: if (con) begin
          ld_skid  = 1'b1;
          state_nx = ST_ONE;
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  // An entry consumed on the flush edge has left the stage, so it is not a drop.
  assign dec      = flush ? (state - {1'b0, con}) : 2'd0;
  assign drop_sum = {1'b0, drop_cnt} + {{(CW-1){1'b0}}, dec};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_keep <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (ld_up) begin
        main_data <= up_data;
        main_keep <= up_keep;
      end else if (ld_skid) begin
        main_data <= skid_data;
        main_keep <= skid_keep;
      end
      drop_cnt <= (drop_sum > DROP_MAX) ? DROP_MAX[CW-1:0] : drop_sum[CW-1:0];
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          skid_data <= '0;
          skid_keep <= '0;
          ready_q   <= 1'b0;
        end else begin
          if (ld_to_skid) begin
            skid_data <= up_data;
            skid_keep <= up_keep;
          end
          ready_q <= (state_nx != ST_TWO);
        end
      end
      assign up_ready = ready_q;
    end else begin : g_noskid
      assign skid_data = '0;
      assign skid_keep = '0;
      assign up_ready  = !dn_valid | dn_ready;
    end
  endgenerate
endmodule
